// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - stream/result bundle between sum source and argmax stage
// result_score is present only when ARGMAX_SCORE_OUT_EN is defined.
interface argmax_classifier_if #(
    parameter int DW   = 22,
    parameter int IDXW = 4
);
    logic                   start;
    logic                   in_valid;
    logic signed [DW-1:0]   in_data;
    logic                   busy;
    logic                   result_valid;
    logic [IDXW-1:0]        result_digit;
    logic                   err_overrun;
`ifdef ARGMAX_SCORE_OUT_EN
    logic signed [DW-1:0]   result_score;
`endif

    modport master (
        output start, in_valid, in_data,
        input  busy, result_valid, result_digit, err_overrun
`ifdef ARGMAX_SCORE_OUT_EN
        , result_score
`endif
    );

    modport slave (
        input  start, in_valid, in_data,
        output busy, result_valid, result_digit, err_overrun
`ifdef ARGMAX_SCORE_OUT_EN
        , result_score
`endif
    );
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - running argmax over NCLASS signed neuron sums per frame
// Optional max-score output enabled by ARGMAX_SCORE_OUT_EN.
module argmax_classifier #(
    parameter int DW     = 22,
    parameter int NCLASS = 10,
    parameter int IDXW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    argmax_classifier_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(NCLASS - 1);

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        cnt_q, cnt_d;
    logic signed [DW-1:0]   max_q, max_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   result_valid_q, result_valid_d;
    logic [IDXW-1:0]        result_digit_q, result_digit_d;
    logic                   err_overrun_q, err_overrun_d;
`ifdef ARGMAX_SCORE_OUT_EN
    logic signed [DW-1:0]   result_score_q, result_score_d;
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        max_d          = max_q;
        idx_d          = idx_q;
        result_valid_d = 1'b0;
        result_digit_d = result_digit_q;
        err_overrun_d  = err_overrun_q;
`ifdef ARGMAX_SCORE_OUT_EN
        result_score_d = result_score_q;
`endif
        // start wins over a coincident in_valid; that sample is simply dropped
        if (bus.start) begin
            state_d       = S_SCAN;
            cnt_d         = '0;
            err_overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_SCAN: begin
                    if (bus.in_valid) begin
                        // strict > keeps the lowest index on ties
                        if (cnt_q == '0 || bus.in_data > max_q) begin
                            max_d = bus.in_data;
                            idx_d = cnt_q;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_d        = S_DONE;
                            result_valid_d = 1'b1;
                            result_digit_d = idx_d;
`ifdef ARGMAX_SCORE_OUT_EN
                            result_score_d = max_d;
`endif
                        end
                    end
                end
                default: begin
                    if (bus.in_valid) begin
                        err_overrun_d = 1'b1;
                    end
                end
            endcase
        end
        busy_d = (state_d == S_SCAN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            max_q          <= '0;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_digit_q <= '0;
            err_overrun_q  <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
            result_score_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            max_q          <= max_d;
            idx_q          <= idx_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_digit_q <= result_digit_d;
            err_overrun_q  <= err_overrun_d;
`ifdef ARGMAX_SCORE_OUT_EN
            result_score_q <= result_score_d;
`endif
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_digit = result_digit_q;
    assign bus.err_overrun  = err_overrun_q;
`ifdef ARGMAX_SCORE_OUT_EN
    assign bus.result_score = result_score_q;
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - directed self-checking bench for argmax_classifier
// Score checks are compiled in only with ARGMAX_SCORE_OUT_EN.
module tb_argmax_classifier;
    localparam int DW = 22;
    localparam int IDXW = 4;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   pulses;
    int   p0;

    argmax_classifier_if #(.DW(DW), .IDXW(IDXW)) bus ();

    argmax_classifier #(.DW(DW), .NCLASS(10), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.result_valid === 1'b1) pulses++;

    task automatic send(input int v);
        logic [31:0] w;
        w = v;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = w[DW-1:0];
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #12;
        total++;
        if ({bus.busy, bus.result_valid, bus.err_overrun, bus.result_digit} !== 7'd0)
            $display("FAIL reset_outputs got=%b want=0",
                     {bus.busy, bus.result_valid, bus.err_overrun, bus.result_digit});
        else passed++;
`ifdef ARGMAX_SCORE_OUT_EN
        total++;
        if (bus.result_score !== 22'd0) $display("FAIL reset_score got=%0d want=0", bus.result_score);
        else passed++;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int v[10] = '{5, -3, 100, 7, 0, 2, 99, -50, 1, 3};
        pulse_start();
        total++;
        if (bus.busy !== 1'b1) $display("FAIL basic_busy got=%b want=1", bus.busy);
        else passed++;
        p0 = pulses;
        for (int i = 0; i < 9; i++) send(v[i]);
        total++;
        if (pulses !== p0 || bus.result_valid !== 1'b0)
            $display("FAIL basic_early_pulse got=%0d want=%0d", pulses - p0, 0);
        else passed++;
        send(v[9]);
        total++;
        if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL basic_done got rv=%b busy=%b want rv=1 busy=0", bus.result_valid, bus.busy);
        else passed++;
        total++;
        if (bus.result_digit !== 4'd2) $display("FAIL basic_digit got=%0d want=2", bus.result_digit);
        else passed++;
`ifdef ARGMAX_SCORE_OUT_EN
        total++;
        if (bus.result_score !== 22'sd100) $display("FAIL basic_score got=%0d want=100", bus.result_score);
        else passed++;
`endif
        @(negedge clk);
        total++;
        if (bus.result_valid !== 1'b0 || bus.result_digit !== 4'd2)
            $display("FAIL basic_hold got rv=%b digit=%0d want rv=0 digit=2", bus.result_valid, bus.result_digit);
        else passed++;
    endtask

    task automatic test_ties();
        pulse_start();
        for (int i = 0; i < 10; i++) send(-1000);
        total++;
        if (bus.result_valid !== 1'b1 || bus.result_digit !== 4'd0)
            $display("FAIL ties_digit got rv=%b digit=%0d want rv=1 digit=0", bus.result_valid, bus.result_digit);
        else passed++;
`ifdef ARGMAX_SCORE_OUT_EN
        total++;
        if (bus.result_score !== -22'sd1000) $display("FAIL ties_score got=%0d want=-1000", bus.result_score);
        else passed++;
`endif
    endtask

    task automatic test_max_last();
        pulse_start();
        for (int i = 0; i < 9; i++) send(10);
        total++;
        if (bus.result_digit !== 4'd0) $display("FAIL last_hold_old got=%0d want=0", bus.result_digit);
        else passed++;
        send(2097151);
        total++;
        if (bus.result_valid !== 1'b1 || bus.result_digit !== 4'd9)
            $display("FAIL last_digit got rv=%b digit=%0d want rv=1 digit=9", bus.result_valid, bus.result_digit);
        else passed++;
`ifdef ARGMAX_SCORE_OUT_EN
        total++;
        if (bus.result_score !== 22'sd2097151) $display("FAIL last_score got=%0d want=2097151", bus.result_score);
        else passed++;
`endif
    endtask

    task automatic test_overrun();
        int v[10] = '{1, 2, 3, 4, 5, 50, 6, 7, 8, 9};
        do_reset();
        send(77);
        total++;
        if (bus.err_overrun !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL ovr_idle got err=%b busy=%b want err=1 busy=0", bus.err_overrun, bus.busy);
        else passed++;
        pulse_start();
        total++;
        if (bus.err_overrun !== 1'b0) $display("FAIL ovr_clear got=%b want=0", bus.err_overrun);
        else passed++;
        for (int i = 0; i < 10; i++) send(v[i]);
        total++;
        if (bus.result_valid !== 1'b1 || bus.result_digit !== 4'd5)
            $display("FAIL ovr_frame got rv=%b digit=%0d want rv=1 digit=5", bus.result_valid, bus.result_digit);
        else passed++;
        p0 = pulses;
        send(999);
        @(negedge clk);
        total++;
        if (bus.err_overrun !== 1'b1 || bus.result_digit !== 4'd5 || pulses !== p0 + 1)
            $display("FAIL ovr_surplus got err=%b digit=%0d pulses=%0d want err=1 digit=5 pulses=%0d",
                     bus.err_overrun, bus.result_digit, pulses - p0, 1);
        else passed++;
    endtask

    task automatic test_abort();
        int v[10] = '{0, 1, 2, 40, 3, -7, 4, 5, 6, 39};
        pulse_start();
        send(1);
        send(500);
        send(2);
        send(3);
        p0 = pulses;
        pulse_start();
        @(negedge clk);
        total++;
        if (pulses !== p0 || bus.busy !== 1'b1 || bus.err_overrun !== 1'b0)
            $display("FAIL abort_restart got pulses=%0d busy=%b err=%b want 0 1 0",
                     pulses - p0, bus.busy, bus.err_overrun);
        else passed++;
        for (int i = 0; i < 10; i++) send(v[i]);
        total++;
        if (bus.result_valid !== 1'b1 || bus.result_digit !== 4'd3)
            $display("FAIL abort_digit got rv=%b digit=%0d want rv=1 digit=3", bus.result_valid, bus.result_digit);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int v[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        pulse_start();
        send(3);
        send(4);
        send(5);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.result_valid, bus.err_overrun, bus.result_digit} !== 7'd0)
            $display("FAIL midrst_async got=%b want=0",
                     {bus.busy, bus.result_valid, bus.err_overrun, bus.result_digit});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 22'sd12345;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.err_overrun !== 1'b0)
            $display("FAIL midrst_start got busy=%b err=%b want busy=1 err=0", bus.busy, bus.err_overrun);
        else passed++;
        p0 = pulses;
        for (int i = 0; i < 9; i++) send(v[i]);
        total++;
        if (pulses !== p0 || bus.result_valid !== 1'b0)
            $display("FAIL midrst_count got pulses=%0d rv=%b want 0 0", pulses - p0, bus.result_valid);
        else passed++;
        send(v[9]);
        total++;
        if (bus.result_valid !== 1'b1 || bus.result_digit !== 4'd8)
            $display("FAIL midrst_digit got rv=%b digit=%0d want rv=1 digit=8", bus.result_valid, bus.result_digit);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        pulses = 0;
        test_reset();
        test_basic();
        test_ties();
        test_max_last();
        test_overrun();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
